// File: rtl/neuron_mac_if.sv
// neuron_mac_if
//   Bundles every handshake and bus signal of the neuron MAC core:
//   the activation stream, the weight/bias write ports and the
//   pre-activation sum output.
//
// Parameters
//   dataWidth  width of activations and weights (signed)
//   sumWidth   width of the accumulated sum (signed)
//   numInputs  number of activation beats per neuron pass
//
// Signals
//   dataIn/dataValid/dataReady  activation stream into the core
//   wEn/wAddr/wData             weight RAM write port
//   biasEn/biasData             bias register write port (product scale)
//   sumOut/sumValid/sumReady    weighted sum plus bias out of the core
//
// Modports
//   master  the side that feeds activations, weights and bias and
//           consumes the sum
//   slave   the MAC core itself
interface neuron_mac_if #(
    parameter int dataWidth = 8,
    parameter int sumWidth  = 24,
    parameter int numInputs = 784
);
    localparam int addrWidth = $clog2(numInputs);

    logic signed [dataWidth-1:0]   dataIn;
    logic                          dataValid;
    logic                          dataReady;
    logic                          wEn;
    logic        [addrWidth-1:0]   wAddr;
    logic signed [dataWidth-1:0]   wData;
    logic                          biasEn;
    logic signed [2*dataWidth-1:0] biasData;
    logic signed [sumWidth-1:0]    sumOut;
    logic                          sumValid;
    logic                          sumReady;

    modport master (
        output dataIn, dataValid, wEn, wAddr, wData, biasEn, biasData, sumReady,
        input  dataReady, sumOut, sumValid
    );

    modport slave (
        input  dataIn, dataValid, wEn, wAddr, wData, biasEn, biasData, sumReady,
        output dataReady, sumOut, sumValid
    );
endinterface

// File: rtl/neuron_mac.sv
// neuron_mac
//   Sequential multiply-accumulate core for one neuron. Streams numInputs
//   signed activations, multiplies each by its stored signed weight,
//   accumulates the products, adds a bias and presents the pre-activation
//   sum on a valid/ready output for the downstream ReLU stage.
//
// Configuration macro
//   NEURON_SAT_EN  when defined, every accumulator add saturates to the
//                  signed sumWidth range; otherwise additions wrap.
//
// Ports
//   clk     sole clock, rising edge
//   resetN  asynchronous active-low reset (weights and bias survive it)
//   bus     neuron_mac_if slave modport (activation stream, weight and
//           bias write ports, sum output handshake)
module neuron_mac #(
    parameter int dataWidth = 8,
    parameter int sumWidth  = 24,
    parameter int numInputs = 784
) (
    input  logic          clk,
    input  logic          resetN,
    neuron_mac_if.slave   bus
);
    localparam int addrWidth = $clog2(numInputs);
    localparam int prodWidth = 2 * dataWidth;
    localparam logic [addrWidth-1:0] lastIdx = addrWidth'(numInputs - 1);

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        BIAS,
        OUT
    } stateType;

    stateType                    state;
    logic        [addrWidth-1:0] count;
    logic signed [dataWidth-1:0] weights [numInputs];
    logic signed [prodWidth-1:0] biasReg;
    logic signed [prodWidth-1:0] product;
    logic                        prodValid;
    logic signed [sumWidth-1:0]  acc;
    logic signed [sumWidth-1:0]  sumReg;
    logic                        sumValidReg;
    logic                        accept;
    logic signed [sumWidth-1:0]  prodExt;
    logic signed [sumWidth-1:0]  biasExt;
    logic signed [sumWidth-1:0]  accPlusProd;
    logic signed [sumWidth-1:0]  accPlusBias;

    // Accumulator adder. With saturation enabled an overflow is detected
    // from the extra carry bit and clamped to the nearest signed limit;
    // the clamp is not sticky, so a later opposite-sign add can move the
    // value back inside the range.
    function automatic logic signed [sumWidth-1:0] accAdd(
        input logic signed [sumWidth-1:0] a,
        input logic signed [sumWidth-1:0] b
    );
`ifdef NEURON_SAT_EN
        logic [sumWidth:0] wide;
        wide = {a[sumWidth-1], a} + {b[sumWidth-1], b};
        if (wide[sumWidth] != wide[sumWidth-1]) begin
            accAdd = wide[sumWidth] ? {1'b1, {(sumWidth-1){1'b0}}}
                                    : {1'b0, {(sumWidth-1){1'b1}}};
        end else begin
            accAdd = wide[sumWidth-1:0];
        end
`else
        accAdd = a + b;
`endif
    endfunction

    // The core only takes beats while accumulating, so ready is a pure
    // decode of the state.
    assign bus.dataReady = (state == ACCUM);
    assign accept        = bus.dataValid && bus.dataReady;
    assign bus.sumOut    = sumReg;
    assign bus.sumValid  = sumValidReg;

    // Signed size casts sign-extend the product and bias into the
    // accumulator width.
    assign prodExt     = sumWidth'(product);
    assign biasExt     = sumWidth'(biasReg);
    assign accPlusProd = accAdd(acc, prodExt);
    assign accPlusBias = accAdd(acc, biasExt);

    // Weight RAM and bias register are deliberately outside the reset
    // domain so a loaded neuron keeps its parameters across resets. The
    // RAM is read combinationally, so a same-cycle write to the address
    // being read still returns the old weight.
    always_ff @(posedge clk) begin
        if (bus.wEn) begin
            weights[bus.wAddr] <= bus.wData;
        end
        if (bus.biasEn) begin
            biasReg <= bus.biasData;
        end
    end

    // Two-stage datapath plus pass sequencing. Stage 1 registers the
    // product of the accepted beat; stage 2 folds the previous product
    // into the accumulator. DRAIN exists so the last beat's product lands
    // before the bias is added, giving a fixed three-cycle latency from
    // the last accepted beat to sumValid.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= ACCUM;
            count       <= '0;
            product     <= '0;
            prodValid   <= 1'b0;
            acc         <= '0;
            sumReg      <= '0;
            sumValidReg <= 1'b0;
        end else begin
            prodValid <= accept;
            if (accept) begin
                product <= prodWidth'(bus.dataIn) * prodWidth'(weights[count]);
            end
            if (prodValid) begin
                acc <= accPlusProd;
            end

            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (count == lastIdx) begin
                            count <= '0;
                            state <= DRAIN;
                        end else begin
                            count <= count + addrWidth'(1);
                        end
                    end
                end
                DRAIN: begin
                    state <= BIAS;
                end
                BIAS: begin
                    acc         <= accPlusBias;
                    sumReg      <= accPlusBias;
                    sumValidReg <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (sumValidReg && bus.sumReady) begin
                        sumValidReg <= 1'b0;
                        acc         <= '0;
                        state       <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end
endmodule
